addr_sequencer: RTL
===================

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
- REQ-001: Clock and reset SHALL be one clock, `clk`, with reset `rst`, asynchronous and active-high.
- REQ-002: `clk  input  1` SHALL be the single clock; all state changes on its rising edge.
- REQ-003: `rst  input  1` SHALL be the asynchronous active-high reset.
- REQ-004: `start  input  1` SHALL be the run request, honoured only in IDLE or HALT.
- REQ-005: `mem_ack  input  1` SHALL be memory access complete, honoured only in FETCH or DATA.
- REQ-006: `op_valid  input  1` SHALL be decoded-op strobe, honoured only in DECODE.
- REQ-007: `op  input  3` SHALL be the operation class:
  - 000 SEQ
  - 001 JREL
  - 010 JREG
  - 011 LDI
  - 100 LDR
  - 111 HALT
  - 101/110 treated as SEQ
- REQ-008: The addressing-unit controls SHALL be `ResetPC`, `PCplusI`, `PCplus1`, `Iplus0`, `Rplus0`, `PCenable`, each `output  1`, driving the addressing unit.
- REQ-009: `mem_req  output  1` SHALL be the memory access request.
- REQ-010: `ir_load  output  1` SHALL be the instruction-register load strobe.
- REQ-011: `busy  output  1` SHALL be high in every state except IDLE, HALT and FAULT.
- REQ-012: `fault  output  1` SHALL be the memory timeout flag.

Function
- REQ-013: FSM states SHALL be IDLE, RESET_PC, FETCH, DECODE, EXEC, DATA, ADVANCE, HALT and FAULT; outputs are Moore, decoded from the state register and the 3-bit registered op (`op_r`).
- REQ-014: At most one of `ResetPC`/`PCplusI`/`PCplus1`/`Iplus0`/`Rplus0` SHALL be high in any cycle.
- REQ-015: IDLE: `start`=1 -> RESET_PC.
- REQ-016: RESET_PC: `ResetPC`=1 and `PCenable`=1 for exactly one cycle -> FETCH.
- REQ-017: FETCH: `mem_req`=1 with all selects 0 and `PCenable`=0, so Address = PC.
  - On `mem_ack`=1: `ir_load`=1 combinationally in the same cycle, then -> DECODE.
- REQ-018: DECODE: on `op_valid`=1, `op` is captured into `op_r` -> EXEC; otherwise the FSM holds.
- REQ-019: EXEC lasts one cycle, with outputs by `op_r`:
  - SEQ: `PCplus1`+`PCenable` -> FETCH
  - JREL: `PCplusI`+`PCenable` -> FETCH
  - JREG: `Rplus0`+`PCenable` -> FETCH
  - LDI/LDR: -> DATA
  - HALT: -> HALT
- REQ-020: DATA: `mem_req`=1 with `Iplus0`=1 (LDI) or `Rplus0`=1 (LDR) and `PCenable`=0, held until `mem_ack`=1 -> ADVANCE.
- REQ-021: ADVANCE: `PCplus1`=1 and `PCenable`=1 for one cycle -> FETCH.
- REQ-022: HALT: all controls 0; `start`=1 -> ADVANCE, resuming at the instruction after the halt.
- REQ-023: `start` outside IDLE/HALT, `mem_ack` outside FETCH/DATA, and `op_valid` outside DECODE SHALL have no effect.
- REQ-024: Minimum instruction latency SHALL be:
  - SEQ/JREL/JREG: 3 cycles (FETCH with immediate ack, DECODE, EXEC)
  - LDI/LDR: 5 cycles

Reset
- REQ-025: `rst`=1 SHALL immediately, without a clock edge, force the state to IDLE, `op_r` to 000, the timeout counter to 0, and every output to 0; this applies mid-operation, including during a pending `mem_req`.
- REQ-026: After `rst` deasserts, the block SHALL stay in IDLE until `start`=1.

Configuration
- REQ-027: Macro `ADDR_SEQ_TIMEOUT_EN` defined: a 4-bit counter SHALL clear on entry to FETCH or DATA and increment each cycle in those states without `mem_ack`.
  - At count 15 with no ack -> FAULT.
  - An ack in the count-15 cycle wins.
  - FAULT: all controls 0, `fault`=1, sticky until `rst`.
- REQ-028: Macro `ADDR_SEQ_TIMEOUT_EN` undefined: no counter and no FAULT state; FETCH/DATA wait indefinitely; `fault` is tied 0.

Verification
- REQ-029: Reset release, then `start`=1 for one cycle -> next cycle `ResetPC`=`PCenable`=1 for exactly 1 cycle, then `mem_req`=1 and `busy`=1.
- REQ-030: FETCH with `mem_ack` on the 3rd cycle, then `op_valid` with `op`=000 -> `mem_req` high 3 cycles, `ir_load` in the ack cycle, EXEC shows `PCplus1`=`PCenable`=1 for 1 cycle, then FETCH.
- REQ-031: `op`=011, DATA `mem_ack` after 2 cycles -> `Iplus0`=`mem_req`=1 for 2 cycles with `PCenable`=0, then `PCplus1`=`PCenable`=1 for 1 cycle; repeat with `op`=100 -> `Rplus0` instead.
- REQ-032: `op`=111 -> HALT with `busy`=0 and all controls 0 for 10 cycles; `start`=1 -> ADVANCE (`PCplus1`) -> FETCH.
- REQ-033: `rst` pulsed mid-DATA between clock edges -> `mem_req`, `Iplus0`, `busy` fall to 0 before the next edge; the state is IDLE afterwards.
- REQ-034: No `mem_ack` in FETCH:
  - With `ADDR_SEQ_TIMEOUT_EN`: `fault`=1 after 15 cycles, sticky across `start`.
  - Without it: `mem_req` is still 1 and `fault`=0 after 40 cycles.

Source files
------------

// File: rtl/addr_sequencer.sv
// Instruction-sequencing FSM that drives the PC/addressing-unit selects and memory handshake.
// Optional memory-timeout watchdog with sticky FAULT state: define ADDR_SEQ_TIMEOUT_EN.
module addr_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mem_ack,
  input  logic       op_valid,
  input  logic [2:0] op,
  output logic       ResetPC,
  output logic       PCplusI,
  output logic       PCplus1,
  output logic       Iplus0,
  output logic       Rplus0,
  output logic       PCenable,
  output logic       mem_req,
  output logic       ir_load,
  output logic       busy,
  output logic       fault
);

  localparam logic [2:0] OP_JREL = 3'b001;
  localparam logic [2:0] OP_JREG = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;
  localparam logic [2:0] OP_LDR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESET_PC,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DATA,
    S_ADVANCE,
    S_HALT
`ifdef ADDR_SEQ_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  state_t     r_state;
  logic [2:0] r_op;

`ifdef ADDR_SEQ_TIMEOUT_EN
  logic [3:0] r_cnt;
  logic       w_wait;
  logic       w_timeout;

  // Only FETCH/DATA are ever entered from other states, so clearing elsewhere equals clear-on-entry.
  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_DATA)) && !mem_ack;
  assign w_timeout = w_wait && (r_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_wait) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE:     if (start) r_state <= S_RESET_PC;
        S_RESET_PC: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) r_state <= S_DECODE;
`ifdef ADDR_SEQ_TIMEOUT_EN
          else if (w_timeout) r_state <= S_FAULT;
`endif
        end
        S_DECODE: begin
          if (op_valid) begin
            r_op    <= op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_LDI, OP_LDR: r_state <= S_DATA;
            OP_HALT:        r_state <= S_HALT;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_DATA: begin
          if (mem_ack) r_state <= S_ADVANCE;
`ifdef ADDR_SEQ_TIMEOUT_EN
          else if (w_timeout) r_state <= S_FAULT;
`endif
        end
        S_ADVANCE: r_state <= S_FETCH;
        S_HALT:    if (start) r_state <= S_ADVANCE;
`ifdef ADDR_SEQ_TIMEOUT_EN
        S_FAULT:   r_state <= S_FAULT;
`endif
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; ir_load is the only output qualified by a live input (the fetch ack).
  always_comb begin
    ResetPC  = 1'b0;
    PCplusI  = 1'b0;
    PCplus1  = 1'b0;
    Iplus0   = 1'b0;
    Rplus0   = 1'b0;
    PCenable = 1'b0;
    mem_req  = 1'b0;
    ir_load  = 1'b0;
    busy     = 1'b0;
    fault    = 1'b0;
    case (r_state)
      S_RESET_PC: begin
        ResetPC  = 1'b1;
        PCenable = 1'b1;
        busy     = 1'b1;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        busy    = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        case (r_op)
          OP_JREL: begin
            PCplusI  = 1'b1;
            PCenable = 1'b1;
          end
          OP_JREG: begin
            Rplus0   = 1'b1;
            PCenable = 1'b1;
          end
          OP_LDI, OP_LDR, OP_HALT: ;
          default: begin
            PCplus1  = 1'b1;
            PCenable = 1'b1;
          end
        endcase
      end
      S_DATA: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        Iplus0  = (r_op == OP_LDI);
        Rplus0  = (r_op != OP_LDI);
      end
      S_ADVANCE: begin
        PCplus1  = 1'b1;
        PCenable = 1'b1;
        busy     = 1'b1;
      end
`ifdef ADDR_SEQ_TIMEOUT_EN
      S_FAULT: fault = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
